// File: rtl/eth_hdr_extract.sv
`default_nettype none
// ============================================================================
//  Module   : eth_hdr_extract
//  Purpose  : Pops bytes from an upstream FIFO and splits each Ethernet frame
//             into a 14-byte header and a payload byte stream. Frames shorter
//             than a full header (runts) are discarded.
//  Ports    : clk, rst (async, active high)
//             r_empty, r_en, r_data[8:0]      FIFO read port (bit 8 = last)
//             hdr_valid, hdr_ready            header handshake
//             dst_mac, src_mac, ethertype,
//             hdr_nopay                       header fields
//             out_valid, out_ready, out_data,
//             out_last                        payload stream
//             frame_cnt, runt_cnt             statistics counters
//  Config   : define ETH_HDR_EXTRACT_STATS_EN to build the statistics
//             counters. Without it, both counter ports are tied to 0.
//  Revision : 1.0 - initial release
// ============================================================================
module eth_hdr_extract #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 r_empty,
    output logic                 r_en,
    input  logic [8:0]           r_data,
    output logic                 hdr_valid,
    input  logic                 hdr_ready,
    output logic [47:0]          dst_mac,
    output logic [47:0]          src_mac,
    output logic [15:0]          ethertype,
    output logic                 hdr_nopay,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [7:0]           out_data,
    output logic                 out_last,
    output logic [CNT_WIDTH-1:0] frame_cnt,
    output logic [CNT_WIDTH-1:0] runt_cnt
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR  = 3'd1,
        S_HOLD = 3'd2,
        S_PAY  = 3'd3,
        S_DROP = 3'd4
    } state_t;

    state_t         state_q, state_d;
    logic [1:0]     cnt_q;          // buffered words
    logic           inflight_q;     // pop issued last cycle, data arrives now
    logic           wr_ptr_q, rd_ptr_q;
    logic [8:0]     buf_q [2];
    logic [3:0]     idx_q, idx_d;
    logic [111:0]   hdr_q, hdr_d;
    logic           nopay_q, nopay_d;

    logic           w_have;
    logic [8:0]     w_head;
    logic           w_pop;
    logic [2:0]     w_occ;

    assign w_have = (cnt_q != 2'd0);
    assign w_head = buf_q[rd_ptr_q];

    // Credit counts both stored words and the pop whose data is still on its
    // way, so every issued pop is guaranteed a free slot.
    assign w_occ = {1'b0, cnt_q} + {2'b00, inflight_q};
    assign r_en  = !rst && !r_empty && (w_occ < 3'd2);

    // Input buffer: 2-entry circular queue fed one cycle after each pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_q[0]   <= '0;
            buf_q[1]   <= '0;
            cnt_q      <= 2'd0;
            inflight_q <= 1'b0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
        end else begin
            inflight_q <= r_en;
            if (inflight_q) begin
                buf_q[wr_ptr_q] <= r_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (w_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            cnt_q <= cnt_q + {1'b0, inflight_q} - {1'b0, w_pop};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= 4'd0;
            hdr_q   <= '0;
            nopay_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            hdr_q   <= hdr_d;
            nopay_q <= nopay_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        hdr_d     = hdr_q;
        nopay_d   = nopay_q;
        w_pop     = 1'b0;
        hdr_valid = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        case (state_q)
            S_IDLE: begin
                idx_d = 4'd0;
                if (w_have) begin
                    state_d = S_HDR;
                end
            end
            S_HDR: begin
                if (w_have) begin
                    w_pop = 1'b1;
                    // First byte ends up in the top bits after 14 shifts.
                    hdr_d = {hdr_q[103:0], w_head[7:0]};
                    if (idx_q == 4'd13) begin
                        nopay_d = w_head[8];
                        state_d = S_HOLD;
                    end else if (w_head[8]) begin
                        state_d = S_IDLE;   // runt: frame ends inside header
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            S_HOLD: begin
                hdr_valid = 1'b1;
                if (hdr_ready) begin
                    state_d = nopay_q ? S_IDLE : S_PAY;
                end
            end
            S_PAY: begin
                out_valid = w_have;
                out_last  = w_have && w_head[8];
                if (w_have && out_ready) begin
                    w_pop = 1'b1;
                    if (w_head[8]) begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DROP: begin
                if (w_have) begin
                    w_pop = 1'b1;
                    if (w_head[8]) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign dst_mac   = hdr_q[111:64];
    assign src_mac   = hdr_q[63:16];
    assign ethertype = hdr_q[15:0];
    assign hdr_nopay = nopay_q;
    assign out_data  = w_head[7:0];

`ifdef ETH_HDR_EXTRACT_STATS_EN
    localparam logic [CNT_WIDTH-1:0] c_cnt_one = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [CNT_WIDTH-1:0] frame_cnt_q, runt_cnt_q;
    logic                 w_frame_inc, w_runt_inc;

    assign w_frame_inc = (state_q == S_HOLD) && hdr_ready;
    assign w_runt_inc  = (state_q == S_HDR) && w_have && w_head[8] &&
                         (idx_q != 4'd13);

    // Counters wrap naturally from all-ones to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt_q <= '0;
            runt_cnt_q  <= '0;
        end else begin
            if (w_frame_inc) begin
                frame_cnt_q <= frame_cnt_q + c_cnt_one;
            end
            if (w_runt_inc) begin
                runt_cnt_q <= runt_cnt_q + c_cnt_one;
            end
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign runt_cnt  = runt_cnt_q;
`else
    assign frame_cnt = '0;
    assign runt_cnt  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_eth_hdr_extract.sv
`default_nettype none
// ============================================================================
//  Module   : tb_eth_hdr_extract
//  Purpose  : Directed and randomised stimulus for eth_hdr_extract with a
//             FIFO model on the read side and a header/payload scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_eth_hdr_extract;

    localparam int CNT_WIDTH = 16;
`ifdef ETH_HDR_EXTRACT_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 r_empty;
    logic                 r_en;
    logic [8:0]           r_data;
    logic                 hdr_valid;
    logic                 hdr_ready;
    logic [47:0]          dst_mac;
    logic [47:0]          src_mac;
    logic [15:0]          ethertype;
    logic                 hdr_nopay;
    logic                 out_valid;
    logic                 out_ready;
    logic [7:0]           out_data;
    logic                 out_last;
    logic [CNT_WIDTH-1:0] frame_cnt;
    logic [CNT_WIDTH-1:0] runt_cnt;

    eth_hdr_extract #(.CNT_WIDTH(CNT_WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .r_empty   (r_empty),
        .r_en      (r_en),
        .r_data    (r_data),
        .hdr_valid (hdr_valid),
        .hdr_ready (hdr_ready),
        .dst_mac   (dst_mac),
        .src_mac   (src_mac),
        .ethertype (ethertype),
        .hdr_nopay (hdr_nopay),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .frame_cnt (frame_cnt),
        .runt_cnt  (runt_cnt)
    );

    always #5 clk = ~clk;

    logic [8:0]   fifo_q [$];
    logic [111:0] exp_hdr_q [$];
    logic         exp_nopay_q [$];
    logic [8:0]   exp_pay_q [$];
    int           checks = 0;
    int           failures = 0;
    int           exp_frames = 0;
    int           exp_runts = 0;
    int           stall_pct = 0;
    int           ready_mode = 0;   // 0: high, 1: random, 2: low
    bit           hdr_block = 1'b0;
    logic [111:0] mon_hdr;

    task automatic check(input string tag, input logic [111:0] got, input logic [111:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [CNT_WIDTH-1:0] cexp(input int v);
        return v[CNT_WIDTH-1:0] & {CNT_WIDTH{STATS_ON}};
    endfunction

    // Upstream FIFO read port: data appears one clock after an accepted pop.
    always @(posedge clk) begin
        if (!rst && r_en && !r_empty && fifo_q.size() > 0) begin
            r_data <= fifo_q.pop_front();
        end
    end

    // Drive ready/empty for the coming edge and score transfers it will make.
    always @(negedge clk) begin
        r_empty = (fifo_q.size() == 0) ||
                  (stall_pct > 0 && $urandom_range(0, 99) < stall_pct);
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
        hdr_ready = !hdr_block;
        if (!rst) begin
            if (hdr_valid && hdr_ready) begin
                if (exp_hdr_q.size() == 0) begin
                    check("hdr_unexpected", {dst_mac, src_mac, ethertype}, 112'h0);
                end else begin
                    mon_hdr = exp_hdr_q.pop_front();
                    check("dst_mac", dst_mac, mon_hdr[111:64]);
                    check("src_mac", src_mac, mon_hdr[63:16]);
                    check("ethertype", ethertype, mon_hdr[15:0]);
                    check("hdr_nopay", hdr_nopay, exp_nopay_q.pop_front());
                end
            end
            if (out_valid && out_ready) begin
                if (exp_pay_q.size() == 0) begin
                    check("pay_unexpected", {out_last, out_data}, 9'h1FF);
                end else begin
                    check("payload", {out_last, out_data}, exp_pay_q.pop_front());
                end
            end
        end
    end

    task automatic send_frame(input int len, input bit rnd, input logic [7:0] base);
        logic [111:0] h;
        logic [7:0]   b;
        logic         l;
        h = '0;
        for (int i = 0; i < len; i++) begin
            b = rnd ? 8'($urandom) : base + 8'(i);
            l = (i == len - 1);
            fifo_q.push_back({l, b});
            if (i < 14) h = {h[103:0], b};
            else        exp_pay_q.push_back({l, b});
        end
        if (len < 14) begin
            exp_runts++;
        end else begin
            exp_hdr_q.push_back(h);
            exp_nopay_q.push_back(len == 14);
            exp_frames++;
        end
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while ((fifo_q.size() != 0 || exp_hdr_q.size() != 0 || exp_pay_q.size() != 0)
               && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain_in_time", n < budget, 1'b1);
        repeat (6) @(negedge clk);
        #2;
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_r_en"},      r_en,      1'b0);
        check({pfx, "_hdr_valid"}, hdr_valid, 1'b0);
        check({pfx, "_out_valid"}, out_valid, 1'b0);
        check({pfx, "_out_last"},  out_last,  1'b0);
        check({pfx, "_hdr_nopay"}, hdr_nopay, 1'b0);
        check({pfx, "_dst_mac"},   dst_mac,   48'h0);
        check({pfx, "_src_mac"},   src_mac,   48'h0);
        check({pfx, "_ethertype"}, ethertype, 16'h0);
        check({pfx, "_out_data"},  out_data,  8'h0);
        check({pfx, "_frame_cnt"}, frame_cnt, '0);
        check({pfx, "_runt_cnt"},  runt_cnt,  '0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        bit  stable;
        logic [111:0] cap;
        rst       = 1'b1;
        r_data    = '0;
        r_empty   = 1'b1;
        out_ready = 1'b1;
        hdr_ready = 1'b1;
        // A pending word keeps r_empty low so r_en gating by reset is visible.
        fifo_q.push_back(9'h0AA);
        repeat (3) @(negedge clk);
        #2;
        check("rst_fifo_nonempty", r_empty, 1'b0);
        check_reset_outputs("rst");
        fifo_q.delete();
        @(negedge clk);
        #2;
        rst = 1'b0;

        // 20-byte frame 00..13h
        send_frame(20, 1'b0, 8'h00);
        wait_done(500);
        check("t1_dst", dst_mac, 48'h000102030405);
        check("t1_src", src_mac, 48'h060708090A0B);
        check("t1_eth", ethertype, 16'h0C0D);
        check("t1_frame_cnt", frame_cnt, cexp(1));

        // 10-byte runt followed by a 16-byte frame
        send_frame(10, 1'b0, 8'h80);
        send_frame(16, 1'b0, 8'h20);
        wait_done(500);
        check("t2_dst", dst_mac, 48'h202122232425);
        check("t2_eth", ethertype, 16'h2C2D);
        check("t2_runt_cnt", runt_cnt, cexp(1));
        check("t2_frame_cnt", frame_cnt, cexp(2));

        // 14-byte frame: header only
        send_frame(14, 1'b0, 8'h50);
        wait_done(500);
        check("t3_nopay", hdr_nopay, 1'b1);
        check("t3_eth", ethertype, 16'h5C5D);
        check("t3_hdr_valid_idle", hdr_valid, 1'b0);
        check("t3_out_valid_idle", out_valid, 1'b0);

        // Header held off for 50 cycles
        hdr_block = 1'b1;
        send_frame(24, 1'b0, 8'h60);
        n = 0;
        while (!hdr_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        #2;
        check("t4_hdr_valid", hdr_valid, 1'b1);
        cap = {dst_mac, src_mac, ethertype};
        check("t4_hdr_value", cap, 112'h606162636465666768696A6B6C6D);
        stable = 1'b1;
        repeat (50) begin
            @(negedge clk);
            #2;
            if ({dst_mac, src_mac, ethertype} !== cap || out_valid || !hdr_valid)
                stable = 1'b0;
        end
        check("t4_hold_stable", stable, 1'b1);
        hdr_block = 1'b0;
        wait_done(500);

        // 100 random frames with random FIFO stalls and output backpressure
        stall_pct  = 30;
        ready_mode = 1;
        for (int f = 0; f < 100; f++) begin
            send_frame($urandom_range(1, 40), 1'b1, 8'h00);
        end
        wait_done(40000);
        stall_pct  = 0;
        ready_mode = 0;
        repeat (4) @(negedge clk);
        #2;
        check("t5_frame_cnt", frame_cnt, cexp(exp_frames));
        check("t5_runt_cnt", runt_cnt, cexp(exp_runts));

        // Reset in the middle of a stalled payload
        ready_mode = 2;
        send_frame(30, 1'b0, 8'h90);
        n = 0;
        while (!(exp_hdr_q.size() == 0 && out_valid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("t6_payload_pending", out_valid, 1'b1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("t6");
        fifo_q.delete();
        exp_pay_q.delete();
        exp_hdr_q.delete();
        exp_nopay_q.delete();
        exp_frames = 0;
        exp_runts  = 0;
        repeat (2) @(negedge clk);
        #2;
        rst        = 1'b0;
        ready_mode = 0;
        send_frame(20, 1'b0, 8'hA0);
        wait_done(500);
        check("t6_dst", dst_mac, 48'hA0A1A2A3A4A5);
        check("t6_frame_cnt", frame_cnt, cexp(1));
        check("t6_runt_cnt", runt_cnt, cexp(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/eth_hdr_extract.md
ETH_HDR_EXTRACT -- requirements
Module: eth_hdr_extract

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 16, width of the statistics counters.
REQ-002 SHALL have ports `clk` (input, 1), the single clock for all logic, and `rst` (input, 1), an asynchronous active-high reset.
REQ-003 SHALL have port `r_empty` (input, 1): the upstream FIFO has no word to read.
REQ-004 SHALL have port `r_en` (output, 1): pop request to the upstream FIFO read port.
REQ-005 SHALL have port `r_data` (input, 9): FIFO word; bit 8 = last byte of frame, bits 7:0 = byte; valid one `clk` after an accepted pop.
REQ-006 SHALL have ports `hdr_valid` (output, 1) and `hdr_ready` (input, 1): header handshake.
REQ-007 SHALL have ports `dst_mac` (output, 48), `src_mac` (output, 48), `ethertype` (output, 16) and `hdr_nopay` (output, 1): header fields; first byte received is the MSB; `hdr_nopay` = frame has no payload.
REQ-008 SHALL have ports `out_valid` (output, 1), `out_ready` (input, 1), `out_data` (output, 8) and `out_last` (output, 1): payload byte stream.
REQ-009 SHALL have ports `frame_cnt` and `runt_cnt` (output, CNT_WIDTH each): statistics.

Function
REQ-010 SHALL treat an accepted pop as `r_en && !r_empty`; `r_data` SHALL be captured exactly one cycle later.
REQ-011 SHALL hold popped words in a 2-entry input buffer; `r_en` = `!r_empty && (occupancy + pops in flight) < 2`, so a pop issues only when the word has a guaranteed slot.
REQ-012 SHALL implement states IDLE, HDR, HOLD, PAY and DROP.
REQ-013 IDLE: goes to HDR when the buffer is non-empty; byte index SHALL be cleared to 0.
REQ-014 HDR: consumes one buffered byte per cycle into a 14-byte shift register (dst 0-5, src 6-11, ethertype 12-13).
REQ-015 HDR, runt: if a byte with the last flag arrives at index < 13, the frame SHALL be discarded, `runt_cnt` SHALL increment, and the state SHALL return to IDLE; no `hdr_valid` is raised.
REQ-016 HDR, header complete: after byte 13, `hdr_valid` SHALL assert the next cycle and the state SHALL be HOLD; `hdr_nopay` = last flag of byte 13.
REQ-017 HOLD: outputs stay stable while `hdr_valid && !hdr_ready`; no payload byte is consumed while in HOLD.
REQ-018 HOLD exit: on handshake, `frame_cnt` SHALL increment; the state SHALL go to PAY, or to IDLE if `hdr_nopay`.
REQ-019 PAY: `out_valid` = buffer non-empty; `out_data`/`out_last` = buffer head; the head pops on `out_valid && out_ready`.
REQ-020 PAY exit: pop of a last-flagged byte SHALL return the state to IDLE.
REQ-021 PAY stall: with `out_ready` low, data SHALL stay stable and the buffer plus in-flight pops SHALL never exceed 2 (no overflow, no loss).
REQ-022 Counters SHALL wrap from all-ones to 0.
REQ-023 Back-to-back frames SHALL be supported: a new frame's first byte may be consumed in the cycle after the previous last byte without loss.
REQ-024 DROP is reserved and SHALL be unreachable; if entered, it discards bytes up to and including the next last flag, then goes to IDLE.

Reset
REQ-025 While `rst` is high, state SHALL be IDLE and the buffer, pops in flight and byte index SHALL be cleared.
REQ-026 While `rst` is high, `r_en`, `hdr_valid`, `out_valid`, `out_last` and `hdr_nopay` SHALL be 0, and `dst_mac`, `src_mac`, `ethertype`, `out_data` and the counters SHALL be 0.
REQ-027 Reset mid-frame SHALL abandon the frame; after reset, the first received byte is treated as a frame start.

Configuration
REQ-028 Macro `ETH_HDR_EXTRACT_STATS_EN` defined: `frame_cnt` and `runt_cnt` SHALL operate as specified in REQ-015 and REQ-018.
REQ-029 Macro `ETH_HDR_EXTRACT_STATS_EN` undefined: the counter logic SHALL be omitted, and the ports SHALL remain and be tied to 0.

Verification
REQ-030 20-byte frame 00..13h, `hdr_ready` and `out_ready` held high -> `dst_mac`=000102030405h, `src_mac`=060708090A0Bh, `ethertype`=0C0Dh; payload 0E..13h with `out_last` on 13h; `frame_cnt`=1.
REQ-031 10-byte runt, then a 16-byte frame -> no `hdr_valid` for the runt, `runt_cnt`=1; second frame header correct; payload of 2 bytes.
REQ-032 14-byte frame -> `hdr_valid` with `hdr_nopay`=1; `out_valid` never asserts; state returns to IDLE.
REQ-033 Randomly toggling `out_ready` and `r_empty` over 100 frames -> payload bytes match the input exactly; the buffer never overflows; `r_en` never asserts while 2 words are outstanding.
REQ-034 `hdr_ready` held low 50 cycles -> header fields stable; no payload emitted; after release, payload is intact.
REQ-035 `rst` pulsed mid-payload -> all outputs 0 during reset; next frame parsed correctly; counters 0, or tied to 0 without the macro.
